sync_block_filtered: RTL and testbench

Parametrised multi-bit CDC synchroniser, successor to the two-flop single-bit sync cell. It carries WIDTH independent asynchronous level signals into the clk domain through a configurable-depth flop chain. A per-channel stability filter (glitch rejection) follows the chain, then registered rising/falling edge pulses. It is used for MDIO/PHY status, link/interrupt lines and cross-domain control levels in the MAC wrapper.

---
 rtl/sync_block_filtered.sv | 70 +++++++
 tb/tb_sync_block_filtered.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_block_filtered.sv
// rtl/sync_block_filtered.sv - multi-bit CDC synchroniser with per-channel glitch filter and edge pulses
module sync_block_filtered #(
    parameter int               WIDTH         = 1,
    parameter int               STAGES        = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] INITIALISE    = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] cnt_active
);

    localparam int             CW      = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_CYCLES);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;
            logic [CW-1:0] r_cnt;
            logic          r_out;
            logic          r_rise;
            logic          r_fall;
            logic          w_sync;

            assign w_sync = r_sync[STAGES-1];

            // Pure flop chain: nothing may sit between the metastability stages.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync <= {STAGES{INITIALISE[gi]}};
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], data_in[gi]};
                end
            end

            // Any return to the held value discards the partial count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_out  <= INITIALISE[gi];
                    r_cnt  <= '0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (w_sync == r_out) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_out  <= w_sync;
                        r_cnt  <= '0;
                        r_rise <= w_sync;
                        r_fall <= ~w_sync;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign data_out[gi]   = r_out;
            assign rise_pulse[gi] = r_rise;
            assign fall_pulse[gi] = r_fall;
            assign cnt_active[gi] = (r_cnt != '0);
        end
    endgenerate

endmodule

// File: tb/tb_sync_block_filtered.sv
// tb/tb_sync_block_filtered.sv - self-checking bench for sync_block_filtered
module tb_sync_block_filtered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] din [4];

    logic [3:0] a_out, a_rise, a_fall, a_cnt;
    logic [3:0] b_out, b_rise, b_fall, b_cnt;
    logic [7:0] c_out, c_rise, c_fall, c_cnt;
    logic [3:0] d_out, d_rise, d_fall, d_cnt;

    sync_block_filtered #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(2), .INITIALISE(4'b0000)) u_a (
        .clk(clk), .reset(reset), .data_in(din[0][3:0]), .data_out(a_out),
        .rise_pulse(a_rise), .fall_pulse(a_fall), .cnt_active(a_cnt));
    sync_block_filtered #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(2), .INITIALISE(4'b1010)) u_b (
        .clk(clk), .reset(reset), .data_in(din[1][3:0]), .data_out(b_out),
        .rise_pulse(b_rise), .fall_pulse(b_fall), .cnt_active(b_cnt));
    sync_block_filtered #(.WIDTH(8), .STAGES(2), .FILTER_CYCLES(0), .INITIALISE(8'h00)) u_c (
        .clk(clk), .reset(reset), .data_in(din[2]), .data_out(c_out),
        .rise_pulse(c_rise), .fall_pulse(c_fall), .cnt_active(c_cnt));
    sync_block_filtered #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(3), .INITIALISE(4'b0000)) u_d (
        .clk(clk), .reset(reset), .data_in(din[3][3:0]), .data_out(d_out),
        .rise_pulse(d_rise), .fall_pulse(d_fall), .cnt_active(d_cnt));

    logic [7:0] act_out [4], act_rise [4], act_fall [4], act_cnt [4];
    always_comb begin
        act_out[0] = {4'h0, a_out}; act_rise[0] = {4'h0, a_rise}; act_fall[0] = {4'h0, a_fall}; act_cnt[0] = {4'h0, a_cnt};
        act_out[1] = {4'h0, b_out}; act_rise[1] = {4'h0, b_rise}; act_fall[1] = {4'h0, b_fall}; act_cnt[1] = {4'h0, b_cnt};
        act_out[2] = c_out;         act_rise[2] = c_rise;         act_fall[2] = c_fall;         act_cnt[2] = c_cnt;
        act_out[3] = {4'h0, d_out}; act_rise[3] = {4'h0, d_rise}; act_fall[3] = {4'h0, d_fall}; act_cnt[3] = {4'h0, d_cnt};
    end

    int         cfg_st   [4] = '{3, 3, 2, 3};
    int         cfg_f    [4] = '{2, 2, 0, 3};
    int         cfg_w    [4] = '{4, 4, 8, 4};
    logic [7:0] cfg_init [4] = '{8'h00, 8'h0A, 8'h00, 8'h00};

    int n_checks = 0;
    int n_errors = 0;

    // Reference: sync is data_in delayed STAGES edges; a bit is accepted once the
    // last FILTER_CYCLES+1 sync samples all agree and differ from the held value.
    logic [7:0] m_pipe [4][$];
    logic [7:0] m_hist [4][$];
    logic [7:0] m_out [4], m_rise [4], m_fall [4], m_act [4];

    task automatic model_edge();
        logic [7:0] sync;
        logic       steady;
        for (int d = 0; d < 4; d++) begin
            if (reset) begin
                m_pipe[d].delete();
                for (int s = 0; s < cfg_st[d]; s++) m_pipe[d].push_back(cfg_init[d]);
                m_hist[d].delete();
                m_out[d] = cfg_init[d]; m_rise[d] = 8'h00; m_fall[d] = 8'h00; m_act[d] = 8'h00;
            end else begin
                sync = m_pipe[d].pop_front();
                m_pipe[d].push_back(din[d]);
                m_hist[d].push_back(sync);
                if (m_hist[d].size() > cfg_f[d] + 1) void'(m_hist[d].pop_front());
                m_rise[d] = 8'h00; m_fall[d] = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    if (m_hist[d].size() == cfg_f[d] + 1 && sync[b] != m_out[d][b]) begin
                        steady = 1'b1;
                        for (int j = 0; j < m_hist[d].size(); j++)
                            if (m_hist[d][j][b] != sync[b]) steady = 1'b0;
                        if (steady) begin
                            m_out[d][b] = sync[b];
                            if (sync[b]) m_rise[d][b] = 1'b1;
                            else         m_fall[d][b] = 1'b1;
                        end
                    end
                end
                m_act[d] = sync ^ m_out[d];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din[0] = 8'h00; din[1] = 8'h0A; din[2] = 8'h00; din[3] = 8'h00;
        tick(); tick();
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if ({act_out[d], act_rise[d], act_fall[d], act_cnt[d]} !== {cfg_init[d], 24'h0}) begin
                n_errors++;
                $display("FAIL reset dut%0d: got out/rise/fall/cnt %h required %h", d,
                         {act_out[d], act_rise[d], act_fall[d], act_cnt[d]}, {cfg_init[d], 24'h0});
            end
        end
        reset = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_latency();
        din[0] = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if ({act_out[0], act_rise[0], act_fall[0]} !== {(e >= 6) ? 8'h01 : 8'h00, (e == 6) ? 8'h01 : 8'h00, 8'h00}) begin
                n_errors++;
                $display("FAIL latency_rise edge%0d: got out/rise/fall %h required %h", e,
                         {act_out[0], act_rise[0], act_fall[0]}, {(e >= 6) ? 8'h01 : 8'h00, (e == 6) ? 8'h01 : 8'h00, 8'h00});
            end
        end
        din[0] = 8'h00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if ({act_out[0], act_rise[0], act_fall[0]} !== {(e >= 6) ? 8'h00 : 8'h01, 8'h00, (e == 6) ? 8'h01 : 8'h00}) begin
                n_errors++;
                $display("FAIL latency_fall edge%0d: got out/rise/fall %h required %h", e,
                         {act_out[0], act_rise[0], act_fall[0]}, {(e >= 6) ? 8'h00 : 8'h01, 8'h00, (e == 6) ? 8'h01 : 8'h00});
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_glitch();
        int hi;
        int rise_e;
        int fall_e;
        hi = 0;
        din[0] = 8'h02;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3) din[0] = 8'h00;
            tick();
            if (act_cnt[0][1]) hi++;
            n_checks++;
            if ({act_out[0][1], act_rise[0][1], act_fall[0][1]} !== 3'b000) begin
                n_errors++;
                $display("FAIL glitch2 edge%0d: got out/rise/fall %b required 000", e,
                         {act_out[0][1], act_rise[0][1], act_fall[0][1]});
            end
        end
        n_checks++;
        if (hi !== 2) begin
            n_errors++;
            $display("FAIL glitch2_cnt_active: got %0d cycles required 2", hi);
        end
        hi = 0; rise_e = -1; fall_e = -1;
        din[0] = 8'h02;
        for (int e = 1; e <= 14; e++) begin
            if (e == 4) din[0] = 8'h00;
            tick();
            if (act_out[0][1]) hi++;
            if (act_rise[0][1] && rise_e < 0) rise_e = e;
            if (act_fall[0][1] && fall_e < 0) fall_e = e;
        end
        n_checks++;
        if ({rise_e, fall_e, hi} !== {32'sd6, 32'sd9, 32'sd3}) begin
            n_errors++;
            $display("FAIL glitch3: got rise_edge %0d fall_edge %0d high %0d required 6 9 3", rise_e, fall_e, hi);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        din[0] = 8'h04;
        repeat (8) tick();
        n_checks++;
        if (act_out[0] !== 8'h04) begin
            n_errors++;
            $display("FAIL midreset_setup: got out %h required 04", act_out[0]);
        end
        din[0] = 8'h00;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (act_cnt[0][2]) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL midreset_pending: got cnt_active %h required bit2 set within 10 cycles", act_cnt[0]);
        end
        din[0] = 8'h04;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({act_out[0], act_rise[0], act_fall[0], act_cnt[0]} !== 32'h0) begin
            n_errors++;
            $display("FAIL midreset_clear: got out/rise/fall/cnt %h required 00000000",
                     {act_out[0], act_rise[0], act_fall[0], act_cnt[0]});
        end
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_checks++;
            if (act_rise[0] !== ((e == 6) ? 8'h04 : 8'h00)) begin
                n_errors++;
                $display("FAIL midreset_rise edge%0d: got rise %h required %h", e, act_rise[0], (e == 6) ? 8'h04 : 8'h00);
            end
        end
        din[0] = 8'h00;
        repeat (10) tick();
    endtask

    task automatic test_init_hold();
        din[1] = 8'h0A;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int e = 0; e <= 50; e++) begin
            if (e > 0) tick();
            n_checks++;
            if ({act_out[1], act_rise[1], act_fall[1]} !== {8'h0A, 16'h0}) begin
                n_errors++;
                $display("FAIL init_hold cycle%0d: got out/rise/fall %h required 0a0000", e,
                         {act_out[1], act_rise[1], act_fall[1]});
            end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] applied [$];
        logic [7:0] exp_out;
        logic [7:0] prev;
        prev = 8'h00;
        for (int n = 0; n < 40; n++) begin
            din[2] = {((n + 1) / 2) % 2 == 1, 6'b0, (n / 2) % 2 == 1};
            applied.push_back(din[2]);
            tick();
            exp_out = (n + 1 >= 3) ? applied[n - 2] : 8'h00;
            n_checks++;
            if ({act_out[2], act_rise[2], act_fall[2]} !== {exp_out, exp_out & ~prev, ~exp_out & prev}) begin
                n_errors++;
                $display("FAIL toggle edge%0d: got out/rise/fall %h required %h", n + 1,
                         {act_out[2], act_rise[2], act_fall[2]}, {exp_out, exp_out & ~prev, ~exp_out & prev});
            end
            prev = exp_out;
        end
        din[2] = 8'h00;
        repeat (6) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            #($urandom_range(0, 3));
            for (int d = 0; d < 4; d++)
                if ($urandom_range(0, 3) == 0)
                    din[d] = din[d] ^ (8'h01 << $urandom_range(0, cfg_w[d] - 1));
            reset = ($urandom_range(0, 499) == 0);
            tick();
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if ({act_out[d], act_rise[d], act_fall[d], act_cnt[d]} !== {m_out[d], m_rise[d], m_fall[d], m_act[d]}) begin
                    n_errors++;
                    $display("FAIL random dut%0d cycle%0d: got out/rise/fall/cnt %h required %h", d, n,
                             {act_out[d], act_rise[d], act_fall[d], act_cnt[d]}, {m_out[d], m_rise[d], m_fall[d], m_act[d]});
                end
                n_checks++;
                if ((act_rise[d] & act_fall[d]) !== 8'h00) begin
                    n_errors++;
                    $display("FAIL random_exclusive dut%0d cycle%0d: got rise&fall %h required 00", d, n,
                             act_rise[d] & act_fall[d]);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 4; d++) din[d] = 8'h00;
        test_reset();
        test_latency();
        test_glitch();
        test_reset_mid();
        test_init_hold();
        test_toggle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
